multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
- Parametrised successor to the single-channel rising-edge FSM.
- Watches WIDTH asynchronous level inputs (buttons, switches, external strobes).
- Per channel: synchronises, optionally debounces, detects rising, falling or both edges, and emits a registered one-cycle pulse.
- Holds a sticky pending flag per channel for software or FSM consumers with W1C clear.

Parameters:
- WIDTH, 4: number of independent channels, 1..32.
- SYNC_STAGES, 2: synchroniser flops per channel, 2..4.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a level change, 1..65535. Used only with DEBOUNCE_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- signal_in  in  WIDTH  raw asynchronous levels.
- mode  in  2  global edge select: 00 rising, 01 falling, 10 both, 11 disabled.
- clear  in  WIDTH  write-1-to-clear of pending bits, synchronous to clk.
- edge_pulse  out  WIDTH  one-cycle pulse per detected edge, registered.
- pending  out  WIDTH  sticky edge flags.
- any_pending  out  1  OR-reduction of pending, registered.

Behaviour:
- Reset (async assert, sync-deasserted externally): sync chains, filtered level, previous level, debounce counters, edge_pulse, pending and any_pending all go to 0.
- A channel held high through reset therefore reports one rising edge after release (mode 00/10).
- Sync chain: signal_in[i] -> SYNC_STAGES flops; the last flop is sync[i].
- Level tracking: prev[i] <= level[i] every cycle, regardless of mode, so a mode change never creates a spurious pulse.
  - level[i] = sync[i] without debounce.
  - level[i] = the filtered level with debounce.
- Detection, evaluated on (level, prev):
  - rise = level & ~prev; fall = ~level & prev.
  - edge_pulse[i] <= rise (00), fall (01), rise|fall (10), 0 (11).
- Latency without debounce: input change before posedge k gives an edge_pulse high during cycle k+SYNC_STAGES (SYNC_STAGES+1 edges including capture). Pulse width is exactly 1 cycle.
- Pending: pending[i] <= (pending[i] & ~clear[i]) | edge_det[i].
  - edge_det is the same-cycle detection term feeding edge_pulse, so pending rises together with edge_pulse.
  - Simultaneous set and clear: set wins, bit stays 1.
- any_pending is registered from next-state pending, so it is coincident with pending.
- Mode 11: no pulses and no new pending; existing pending bits hold until cleared.
- Channels are fully independent. Simultaneous edges on several channels all pulse in the same cycle.
- Input toggling every cycle without debounce: each synchronised transition pulses (mode 10 gives a pulse every cycle).

Optional Feature:
- Macro: MULTI_EDGE_DEBOUNCE_EN.
- Defined: per-channel counter, width $clog2(DEBOUNCE_CYCLES+1).
  - When sync != filt, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still different, filt <= sync and the counter goes to 0.
  - When sync == filt, the counter goes to 0.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
  - Added latency: DEBOUNCE_CYCLES cycles. Counter saturation is impossible by construction.
- Undefined: no counters; level = sync. DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package multi_edge_pkg:
  - mode encodings MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11;
  - max WIDTH and SYNC_STAGES limits.
- Sub-module edge_det_channel: sync chain, optional debounce, prev register and edge_det for one bit.
- The top generates WIDTH instances and owns pending/any_pending.

Test Plan:
- Reset release with signal_in=4'b0000, mode=00; raise bit0 before posedge 5 -> edge_pulse=4'b0001 for one cycle at cycle 5+SYNC_STAGES; pending=0001; any_pending=1.
- mode=01, bit2 1->0 -> single pulse on bit2 only. mode=10 with bit1 0->1->0 ten cycles apart -> two pulses on bit1.
- pending[0]=1, clear=0001 in the same cycle as a new bit0 edge -> pending[0] stays 1. clear alone next cycle -> 0; any_pending=0.
- mode=11, toggle all bits -> edge_pulse=0 and pending unchanged. Switch to mode=00 while inputs are stable -> no pulse.
- Assert rst mid-pulse with signal_in=4'b1111 -> outputs 0 immediately (asynchronous). After release -> one rising pulse on all four bits.
- With MULTI_EDGE_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-cycle high glitch -> no pulse. 4-cycle high -> one pulse, 4 cycles later than the non-debounced latency.

Source files
------------

// File: rtl/multi_edge_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-select
// encodings and the legal ranges of the structural parameters.
package multi_edge_pkg;

  // Global edge-select encoding driven on the mode port.
  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_t;

  localparam int MAX_WIDTH        = 32;
  localparam int MIN_SYNC_STAGES  = 2;
  localparam int MAX_SYNC_STAGES  = 4;
  localparam int MAX_DEBOUNCE     = 65535;

endpackage

// File: rtl/multi_edge_detector_channel.sv
// One channel of the edge detector: synchroniser chain, optional debounce
// filter, previous-level register and the combinational edge_det term.
// Optional debounce filter is built when MULTI_EDGE_DEBOUNCE_EN is defined.
module edge_det_channel
  import multi_edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  signal_in,
  input  mode_t mode,
  output logic  edge_det
);

  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("edge_det_channel: SYNC_STAGES out of range");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > MAX_DEBOUNCE) begin : g_bad_debounce
    $error("edge_det_channel: DEBOUNCE_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   level;
  logic                   prev;
  logic                   rise;
  logic                   fall;

  // Shift the raw asynchronous level through the synchroniser flops.
  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], signal_in};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             filt;

  // Accept a new level only after it has differed from the filtered level
  // for DEBOUNCE_CYCLES consecutive cycles; any return to agreement restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync_bit != filt) begin
      if (cnt == CNT_LAST) begin
        filt <= sync_bit;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  assign level = filt;
`else
  assign level = sync_bit;
`endif

  // Track the level every cycle independent of mode, so switching mode
  // never manufactures an edge out of stale history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

  // Select which transitions count as an edge for the current mode.
  // NOTE: the default assignment up front keeps this purely combinational
  // even if a case arm is later left without an assignment.
  always_comb begin
    edge_det = 1'b0;
    case (mode)
      MODE_RISE: edge_det = rise;
      MODE_FALL: edge_det = fall;
      MODE_BOTH: edge_det = rise | fall;
      default:   edge_det = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: WIDTH independent channels producing
// registered one-cycle edge pulses and sticky write-1-to-clear pending flags.
// Optional debounce filter is built when MULTI_EDGE_DEBOUNCE_EN is defined.
module multi_edge_detector
  import multi_edge_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] signal_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] pending,
  output logic             any_pending
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("multi_edge_detector: WIDTH out of range");
  end

  mode_t            mode_sel;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] pending_next;

  assign mode_sel = mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .signal_in (signal_in[i]),
      .mode      (mode_sel),
      .edge_det  (edge_det[i])
    );
  end

  // A same-cycle edge overrides a clear, so an edge is never lost.
  assign pending_next = (pending & ~clear) | edge_det;

  // Register pulses, sticky flags and their OR so all three move together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_pulse  <= '0;
      pending     <= '0;
      any_pending <= 1'b0;
    end else begin
      edge_pulse  <= edge_det;
      pending     <= pending_next;
      any_pending <= |pending_next;
    end
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: directed scenarios with
// literal expectations plus a randomized run against a delay-line model.
// Define MULTI_EDGE_DEBOUNCE_EN to exercise the debounce build.
module tb_multi_edge_detector;

  localparam int WIDTH           = 4;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int DEB_LAT = DEBOUNCE_CYCLES;
`else
  localparam int DEB_LAT = 0;
`endif
  // Cycles from the capturing posedge to the posedge that registers the pulse.
  localparam int LAT   = SYNC_STAGES + DEB_LAT;
  localparam int DEPTH = SYNC_STAGES + DEBOUNCE_CYCLES + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] signal_in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] clear;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] pending;
  logic             any_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_edge_detector #(
    .WIDTH           (WIDTH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .signal_in   (signal_in),
    .mode        (mode),
    .clear       (clear),
    .edge_pulse  (edge_pulse),
    .pending     (pending),
    .any_pending (any_pending)
  );

  // Reference model: raw samples and filtered levels kept as history queues
  // (newest first). The level during a cycle is the raw sample taken
  // SYNC_STAGES-1 posedges earlier; with debounce it only follows a window
  // of DEBOUNCE_CYCLES identical synchronised samples.
  logic [WIDTH-1:0] raw_q[$];
  logic [WIDTH-1:0] lvl_q[$];
  logic [WIDTH-1:0] exp_pulse;
  logic [WIDTH-1:0] exp_pending;
  logic             exp_any;

  initial begin : ref_model
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] old;
    logic [WIDTH-1:0] nl;
`ifdef MULTI_EDGE_DEBOUNCE_EN
    logic [WIDTH-1:0] win_and;
    logic [WIDTH-1:0] win_or;
`endif
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        raw_q.delete();
        lvl_q.delete();
        for (int k = 0; k < DEPTH; k++) raw_q.push_back('0);
        lvl_q.push_back('0);
        lvl_q.push_back('0);
        exp_pulse   = '0;
        exp_pending = '0;
        exp_any     = 1'b0;
      end else begin
        cur = lvl_q[0];
        old = lvl_q[1];
        case (mode)
          2'b00:   det = cur & ~old;
          2'b01:   det = ~cur & old;
          2'b10:   det = cur ^ old;
          default: det = '0;
        endcase
        exp_pulse   = det;
        exp_pending = (exp_pending & ~clear) | det;
        exp_any     = |exp_pending;
        raw_q.push_front(signal_in);
        void'(raw_q.pop_back());
`ifdef MULTI_EDGE_DEBOUNCE_EN
        win_and = '1;
        win_or  = '0;
        for (int j = 0; j < DEBOUNCE_CYCLES; j++) begin
          win_and = win_and & raw_q[SYNC_STAGES + j];
          win_or  = win_or  | raw_q[SYNC_STAGES + j];
        end
        nl = win_and | (cur & win_or);
`else
        nl = raw_q[SYNC_STAGES - 1];
`endif
        lvl_q.push_front(nl);
        void'(lvl_q.pop_back());
      end
    end
  end

  task automatic cycle_n(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    signal_in = '0;
    mode      = 2'b00;
    clear     = '0;
    cycle_n(3);
    checks++;
    if (edge_pulse !== '0) begin
      errors++;
      $display("FAIL reset_pulse: got %b want 0000", edge_pulse);
    end
    checks++;
    if (pending !== '0) begin
      errors++;
      $display("FAIL reset_pending: got %b want 0000", pending);
    end
    checks++;
    if (any_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_any: got %b want 0", any_pending);
    end
  endtask

  task automatic test_rise_latency();
    logic [WIDTH-1:0] want;
    rst = 1'b0;
    for (int k = 1; k <= 5 + LAT + 3; k++) begin
      cycle_n(1);
      want = (k == 5 + LAT) ? 4'b0001 : 4'b0000;
      checks++;
      if (edge_pulse !== want) begin
        errors++;
        $display("FAIL rise_latency cyc %0d: got %b want %b", k, edge_pulse, want);
      end
      if (k == 4) signal_in[0] = 1'b1;
    end
    checks++;
    if (pending !== 4'b0001) begin
      errors++;
      $display("FAIL rise_pending: got %b want 0001", pending);
    end
    checks++;
    if (any_pending !== 1'b1) begin
      errors++;
      $display("FAIL rise_any: got %b want 1", any_pending);
    end
  endtask

  task automatic test_fall_both();
    int               cnt;
    logic [WIDTH-1:0] others;
    mode = 2'b01;
    signal_in[2] = 1'b1;
    others = '0;
    for (int k = 0; k < LAT + 4; k++) begin
      cycle_n(1);
      others = others | edge_pulse;
    end
    checks++;
    if (others !== '0) begin
      errors++;
      $display("FAIL fall_mode_rise_ignored: got %b want 0000", others);
    end
    signal_in[2] = 1'b0;
    cnt = 0;
    others = '0;
    for (int k = 0; k < LAT + 4; k++) begin
      cycle_n(1);
      cnt += int'(edge_pulse[2]);
      others = others | (edge_pulse & 4'b1011);
    end
    checks++;
    if (cnt != 1 || others !== '0) begin
      errors++;
      $display("FAIL fall_single: got %0d pulses others %b want 1 pulses others 0000", cnt, others);
    end
    mode = 2'b10;
    signal_in[1] = 1'b1;
    cnt = 0;
    others = '0;
    for (int k = 0; k < 10; k++) begin
      cycle_n(1);
      cnt += int'(edge_pulse[1]);
      others = others | (edge_pulse & 4'b1101);
    end
    signal_in[1] = 1'b0;
    for (int k = 0; k < LAT + 4; k++) begin
      cycle_n(1);
      cnt += int'(edge_pulse[1]);
      others = others | (edge_pulse & 4'b1101);
    end
    checks++;
    if (cnt != 2 || others !== '0) begin
      errors++;
      $display("FAIL both_two_pulses: got %0d pulses others %b want 2 pulses others 0000", cnt, others);
    end
    checks++;
    if (pending !== 4'b0111) begin
      errors++;
      $display("FAIL both_pending: got %b want 0111", pending);
    end
  endtask

  task automatic test_clear_collision();
    mode = 2'b10;
    signal_in[0] = 1'b0;
    cycle_n(LAT);
    clear = 4'b0001;
    cycle_n(1);
    checks++;
    if (edge_pulse[0] !== 1'b1 || pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_set: got pulse %b pending %b want pulse 1 pending 1",
               edge_pulse[0], pending[0]);
    end
    clear = 4'b1111;
    cycle_n(1);
    checks++;
    if (pending !== '0 || any_pending !== 1'b0) begin
      errors++;
      $display("FAIL clear_alone: got pending %b any %b want 0000 0", pending, any_pending);
    end
    clear = '0;
  endtask

  task automatic test_mode_off();
    mode = 2'b00;
    signal_in[3] = 1'b1;
    cycle_n(LAT + 3);
    checks++;
    if (pending !== 4'b1000 || edge_pulse !== '0) begin
      errors++;
      $display("FAIL off_setup: got pending %b pulse %b want 1000 0000", pending, edge_pulse);
    end
    mode = 2'b11;
    for (int k = 0; k < 12 + LAT + 4; k++) begin
      if (k < 12) signal_in = ~signal_in;
      else signal_in = 4'b0101;
      cycle_n(1);
      checks++;
      if (edge_pulse !== '0 || pending !== 4'b1000) begin
        errors++;
        $display("FAIL mode_off cyc %0d: got pulse %b pending %b want 0000 1000", k, edge_pulse, pending);
      end
    end
    mode = 2'b00;
    for (int k = 0; k < 8; k++) begin
      cycle_n(1);
      checks++;
      if (edge_pulse !== '0 || pending !== 4'b1000) begin
        errors++;
        $display("FAIL mode_switch cyc %0d: got pulse %b pending %b want 0000 1000", k, edge_pulse, pending);
      end
    end
  endtask

  task automatic test_async_reset();
    logic             found;
    logic [WIDTH-1:0] want;
    mode = 2'b00;
    signal_in = '0;
    cycle_n(LAT + 3);
    signal_in = 4'b1111;
    found = 1'b0;
    for (int k = 0; k < LAT + 4 && !found; k++) begin
      cycle_n(1);
      if (edge_pulse === 4'b1111) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_setup_pulse: got %b want 1111 within budget", edge_pulse);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (edge_pulse !== '0 || pending !== '0 || any_pending !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pulse %b pending %b any %b want 0000 0000 0",
               edge_pulse, pending, any_pending);
    end
    cycle_n(2);
    rst = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      cycle_n(1);
      want = (k == LAT + 1) ? 4'b1111 : 4'b0000;
      checks++;
      if (edge_pulse !== want) begin
        errors++;
        $display("FAIL post_reset_rise cyc %0d: got %b want %b", k, edge_pulse, want);
      end
    end
    checks++;
    if (pending !== 4'b1111 || any_pending !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pending: got %b %b want 1111 1", pending, any_pending);
    end
  endtask

`ifdef MULTI_EDGE_DEBOUNCE_EN
  task automatic test_debounce();
    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] want;
    mode = 2'b00;
    signal_in = '0;
    clear = 4'b1111;
    cycle_n(1);
    clear = '0;
    cycle_n(LAT + 3);
    signal_in[0] = 1'b1;
    cycle_n(DEBOUNCE_CYCLES - 1);
    signal_in[0] = 1'b0;
    seen = '0;
    for (int k = 0; k < LAT + 6; k++) begin
      cycle_n(1);
      seen = seen | edge_pulse;
    end
    checks++;
    if (seen !== '0) begin
      errors++;
      $display("FAIL debounce_glitch: got %b want 0000", seen);
    end
    signal_in[0] = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      cycle_n(1);
      want = (k == LAT + 1) ? 4'b0001 : 4'b0000;
      checks++;
      if (edge_pulse !== want) begin
        errors++;
        $display("FAIL debounce_accept cyc %0d: got %b want %b", k, edge_pulse, want);
      end
      if (k == DEBOUNCE_CYCLES) signal_in[0] = 1'b0;
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(0, 3) == 0) signal_in[i] = ~signal_in[i];
        clear[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      cycle_n(1);
      checks++;
      if (edge_pulse !== exp_pulse) begin
        errors++;
        $display("FAIL random_pulse cyc %0d: got %b want %b", k, edge_pulse, exp_pulse);
      end
      checks++;
      if (pending !== exp_pending) begin
        errors++;
        $display("FAIL random_pending cyc %0d: got %b want %b", k, pending, exp_pending);
      end
      checks++;
      if (any_pending !== exp_any) begin
        errors++;
        $display("FAIL random_any cyc %0d: got %b want %b", k, any_pending, exp_any);
      end
    end
    clear = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_rise_latency();
    test_fall_both();
    test_clear_collision();
    test_mode_off();
    test_async_reset();
`ifdef MULTI_EDGE_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
